// File: rtl/camera_stream_pkg.sv
// Shared types, colour constants and pattern encodings for the camera sensor emulator.
package camera_stream_pkg;

    localparam int unsigned PIXEL_W = 16;
    localparam int unsigned CTR_W   = 16;

    typedef enum logic [2:0] {
        StIdle,
        StVsync,
        StVback,
        StActive,
        StVfront
    } cam_state_e;

    localparam logic [1:0] PAT_SOLID = 2'd0;
    localparam logic [1:0] PAT_RAMP  = 2'd1;
    localparam logic [1:0] PAT_BARS  = 2'd2;
    localparam logic [1:0] PAT_COUNT = 2'd3;

    localparam logic [PIXEL_W-1:0] BAR_WHITE   = 16'hFFFF;
    localparam logic [PIXEL_W-1:0] BAR_YELLOW  = 16'hFFE0;
    localparam logic [PIXEL_W-1:0] BAR_CYAN    = 16'h07FF;
    localparam logic [PIXEL_W-1:0] BAR_GREEN   = 16'h07E0;
    localparam logic [PIXEL_W-1:0] BAR_MAGENTA = 16'hF81F;
    localparam logic [PIXEL_W-1:0] BAR_RED     = 16'hF800;
    localparam logic [PIXEL_W-1:0] BAR_BLUE    = 16'h001F;
    localparam logic [PIXEL_W-1:0] BAR_BLACK   = 16'h0000;

    function automatic logic [PIXEL_W-1:0] bar_colour(input logic [2:0] idx);
        logic [PIXEL_W-1:0] c;
        unique case (idx)
            3'd0:    c = BAR_WHITE;
            3'd1:    c = BAR_YELLOW;
            3'd2:    c = BAR_CYAN;
            3'd3:    c = BAR_GREEN;
            3'd4:    c = BAR_MAGENTA;
            3'd5:    c = BAR_RED;
            3'd6:    c = BAR_BLUE;
            default: c = BAR_BLACK;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/camera_pattern_pixel.sv
// Combinational test-pattern generator: selects the RGB565 pixel and returns the byte
// currently on the wire (high byte first).
module camera_pattern_pixel
    import camera_stream_pkg::*;
(
    input  logic [1:0]         pattern_i,
    input  logic [8:0]         x_i,
    input  logic [2:0]         bar_i,
    input  logic [PIXEL_W-1:0] solid_i,
    input  logic [7:0]         byte_cnt_i,
    input  logic               byte_sel_i,
    output logic [7:0]         data_byte_o
);

    logic [PIXEL_W-1:0] pixel;
    logic               unused_x;

    assign unused_x = ^x_i[2:0];

    always_comb begin
        pixel = '0;
        unique case (pattern_i)
            PAT_SOLID: pixel = solid_i;
            PAT_RAMP:  pixel = {x_i[8:4], x_i[8:3], x_i[8:4]};
            PAT_BARS:  pixel = bar_colour(bar_i);
            PAT_COUNT: pixel = '0;
        endcase
    end

    always_comb begin
        if (pattern_i == PAT_COUNT) begin
            data_byte_o = byte_cnt_i;
        end else if (byte_sel_i) begin
            data_byte_o = pixel[7:0];
        end else begin
            data_byte_o = pixel[15:8];
        end
    end

endmodule

// File: rtl/camera_stream_gen.sv
// OV7670-style sensor emulator: free-running pclk plus href/vsync/data framing that
// advances only on pclk falling edges, so a receiver sees stable data on pclk rise.
module camera_stream_gen
    import camera_stream_pkg::*;
#(
    parameter int unsigned H_ACTIVE    = 640,
    parameter int unsigned V_ACTIVE    = 480,
    parameter int unsigned H_BLANK     = 144,
    parameter int unsigned VSYNC_LINES = 3,
    parameter int unsigned V_BACK      = 17,
    parameter int unsigned V_FRONT     = 10,
    parameter int unsigned PCLK_HALF   = 2
) (
    input  logic               clk_50,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         pattern_sel,
    input  logic [PIXEL_W-1:0] solid_color,
    output logic               camera_pclk,
    output logic               camera_href,
    output logic               camera_vsync,
    output logic [7:0]         camera_data,
    output logic               frame_done,
    output logic               busy
);

    localparam int unsigned LINE_TICKS = 2 * H_ACTIVE + H_BLANK;
    localparam int unsigned BAR_W      = H_ACTIVE / 8;

    logic [CTR_W-1:0] half_cnt_q;
    logic             pclk_q;
    logic             half_edge;
    logic             tick;

    cam_state_e         state_q, state_d;
    logic [CTR_W-1:0]   col_q, col_d;
    logic [CTR_W-1:0]   line_q, line_d;
    logic [2:0]         bar_q, bar_d;
    logic [CTR_W-1:0]   bar_px_q, bar_px_d;
    logic [7:0]         byte_cnt_q, byte_cnt_d;
    logic [1:0]         pattern_q, pattern_d;
    logic [PIXEL_W-1:0] solid_q, solid_d;
    logic               href_q, vsync_q, frame_done_q;
    logic [7:0]         data_q;

    logic [CTR_W-1:0]   state_lines;
    logic               eol, last_line, start, frame_end, href_d;
    logic [7:0]         data_byte;

    assign half_edge = (half_cnt_q == CTR_W'(PCLK_HALF - 1));
    // Framing advances only where pclk is about to fall.
    assign tick      = half_edge && pclk_q;

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            half_cnt_q <= '0;
            pclk_q     <= 1'b0;
        end else if (half_edge) begin
            half_cnt_q <= '0;
            pclk_q     <= ~pclk_q;
        end else begin
            half_cnt_q <= half_cnt_q + 1'b1;
        end
    end

    always_comb begin
        case (state_q)
            StVsync:  state_lines = CTR_W'(VSYNC_LINES);
            StVback:  state_lines = CTR_W'(V_BACK);
            StActive: state_lines = CTR_W'(V_ACTIVE);
            StVfront: state_lines = CTR_W'(V_FRONT);
            default:  state_lines = '0;
        endcase
    end

    assign eol       = (col_q == CTR_W'(LINE_TICKS - 1));
    assign last_line = (line_q == state_lines - 1'b1);

    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        line_d    = line_q;
        pattern_d = pattern_q;
        solid_d   = solid_q;
        start     = 1'b0;
        frame_end = 1'b0;
        if (state_q == StIdle) begin
            col_d  = '0;
            line_d = '0;
            start  = enable;
        end else begin
            col_d = eol ? '0 : col_q + 1'b1;
            if (eol) begin
                if (last_line) begin
                    line_d = '0;
                    case (state_q)
                        StVsync:  state_d = StVback;
                        StVback:  state_d = StActive;
                        StActive: state_d = StVfront;
                        StVfront: begin
                            frame_end = 1'b1;
                            start     = enable;
                            state_d   = StIdle;
                        end
                        default:  state_d = StIdle;
                    endcase
                end else begin
                    line_d = line_q + 1'b1;
                end
            end
        end
        // Inputs are sampled only at frame start and held for the whole frame.
        if (start) begin
            state_d   = StVsync;
            col_d     = '0;
            line_d    = '0;
            pattern_d = pattern_sel;
            solid_d   = solid_color;
        end
    end

    assign href_d = (state_d == StActive) && (col_d < CTR_W'(2 * H_ACTIVE));

    // Bar index steps every BAR_W pixels without dividing the column.
    always_comb begin
        bar_d    = bar_q;
        bar_px_d = bar_px_q;
        if (col_d == '0) begin
            bar_d    = '0;
            bar_px_d = '0;
        end else if (!col_d[0]) begin
            if (bar_px_q == CTR_W'(BAR_W - 1)) begin
                bar_px_d = '0;
                bar_d    = bar_q + 1'b1;
            end else begin
                bar_px_d = bar_px_q + 1'b1;
            end
        end
    end

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        if (start) begin
            byte_cnt_d = '0;
        end else if (href_d) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
        end
    end

    camera_pattern_pixel u_pattern (
        .pattern_i   (pattern_d),
        .x_i         (col_d[9:1]),
        .bar_i       (bar_d),
        .solid_i     (solid_d),
        .byte_cnt_i  (byte_cnt_q),
        .byte_sel_i  (col_d[0]),
        .data_byte_o (data_byte)
    );

    always_ff @(posedge clk_50 or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            col_q        <= '0;
            line_q       <= '0;
            bar_q        <= '0;
            bar_px_q     <= '0;
            byte_cnt_q   <= '0;
            pattern_q    <= '0;
            solid_q      <= '0;
            href_q       <= 1'b0;
            vsync_q      <= 1'b0;
            data_q       <= '0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            if (tick) begin
                state_q      <= state_d;
                col_q        <= col_d;
                line_q       <= line_d;
                bar_q        <= bar_d;
                bar_px_q     <= bar_px_d;
                byte_cnt_q   <= byte_cnt_d;
                pattern_q    <= pattern_d;
                solid_q      <= solid_d;
                href_q       <= href_d;
                vsync_q      <= (state_d == StVsync);
                data_q       <= href_d ? data_byte : 8'h00;
                frame_done_q <= frame_end;
            end
        end
    end

    assign camera_pclk  = pclk_q;
    assign camera_href  = href_q;
    assign camera_vsync = vsync_q;
    assign camera_data  = data_q;
    assign frame_done   = frame_done_q;
    assign busy         = (state_q != StIdle);

endmodule

// File: tb/tb_camera_stream_gen.sv
// Directed bench for camera_stream_gen with a tiny frame geometry.
module tb_camera_stream_gen;

    logic        clk_50;
    logic        reset;
    logic        enable;
    logic [1:0]  pattern_sel;
    logic [15:0] solid_color;
    logic        camera_pclk, camera_href, camera_vsync, frame_done, busy;
    logic [7:0]  camera_data;

    camera_stream_gen #(
        .H_ACTIVE    (8),
        .V_ACTIVE    (4),
        .H_BLANK     (4),
        .VSYNC_LINES (1),
        .V_BACK      (1),
        .V_FRONT     (1),
        .PCLK_HALF   (1)
    ) dut (
        .clk_50       (clk_50),
        .reset        (reset),
        .enable       (enable),
        .pattern_sel  (pattern_sel),
        .solid_color  (solid_color),
        .camera_pclk  (camera_pclk),
        .camera_href  (camera_href),
        .camera_vsync (camera_vsync),
        .camera_data  (camera_data),
        .frame_done   (frame_done),
        .busy         (busy)
    );

    initial begin
        clk_50 = 1'b0;
        forever #5 clk_50 = ~clk_50;
    end

    typedef struct {
        logic [1:0]   pat;
        logic [15:0]  solid;
        logic [127:0] line0;
    } vec_t;

    vec_t vecs [4];

    int n_pass = 0;
    int n_total = 0;

    // One record per pclk rising edge, as a receiver would see it.
    logic       rec_href[$];
    logic       rec_vsync[$];
    logic [7:0] rec_data[$];
    int         done_at[$];
    logic       pclk_prev;
    int         href_seen;

    int           vs_idx, done_idx, n_runs, n_vs, n_badlen, n_dirty;
    logic [127:0] lines [4];

    function automatic void check(string name, logic [127:0] act, logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endfunction

    task automatic clear_rec();
        rec_href.delete();
        rec_vsync.delete();
        rec_data.delete();
        done_at.delete();
        href_seen = 0;
        pclk_prev = camera_pclk;
    endtask

    task automatic step();
        @(negedge clk_50);
        if (camera_pclk && !pclk_prev) begin
            rec_href.push_back(camera_href);
            rec_vsync.push_back(camera_vsync);
            rec_data.push_back(camera_data);
            if (camera_href) href_seen++;
        end
        pclk_prev = camera_pclk;
        if (frame_done) done_at.push_back(rec_href.size());
    endtask

    task automatic reset_dut();
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk_50);
        reset = 1'b0;
        clear_rec();
    endtask

    task automatic run_until_done(input int budget);
        int c = 0;
        while (done_at.size() == 0 && c < budget) begin
            step();
            c++;
        end
    endtask

    task automatic analyze();
        int run_len = 0;
        vs_idx = -1;
        for (int i = 0; i < rec_href.size(); i++)
            if (rec_vsync[i] && vs_idx < 0) vs_idx = i;
        done_idx = (done_at.size() > 0) ? done_at[0] : rec_href.size();
        n_runs = 0; n_vs = 0; n_badlen = 0; n_dirty = 0;
        for (int l = 0; l < 4; l++) lines[l] = '0;
        if (vs_idx >= 0) begin
            for (int i = vs_idx; i < done_idx; i++) begin
                if (rec_vsync[i]) n_vs++;
                if (rec_href[i]) begin
                    if (n_runs < 4 && run_len < 16) lines[n_runs][127-8*run_len -: 8] = rec_data[i];
                    run_len++;
                end else begin
                    if (rec_data[i] != 8'h00) n_dirty++;
                    if (run_len > 0) begin
                        if (run_len != 16) n_badlen++;
                        n_runs++;
                        run_len = 0;
                    end
                end
            end
        end
    endtask

    int           toggles, quiet_bad, c, first_href, pre_href, late_vs;
    logic         prev_pclk, nogap;
    logic [8:0]   first2;
    logic [127:0] exp_line;

    initial begin
        vecs[0] = '{pat: 2'd0, solid: 16'hF81F, line0: 128'hF81FF81FF81FF81FF81FF81FF81FF81F};
        vecs[1] = '{pat: 2'd2, solid: 16'h1234, line0: 128'hFFFFFFE007FF07E0F81FF800001F0000};
        vecs[2] = '{pat: 2'd3, solid: 16'hABCD, line0: 128'h000102030405060708090A0B0C0D0E0F};
        vecs[3] = '{pat: 2'd1, solid: 16'hFFFF, line0: 128'h0};

        reset = 1'b1; enable = 1'b0; pattern_sel = 2'd0; solid_color = 16'h0;
        repeat (3) @(negedge clk_50);
        check("reset_outputs",
              {camera_pclk, camera_href, camera_vsync, camera_data, frame_done, busy}, 0);
        reset = 1'b0;

        // Idle with enable low: pclk toggles every clk_50 cycle, everything else quiet.
        toggles = 0; quiet_bad = 0; prev_pclk = camera_pclk;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_50);
            if (camera_pclk != prev_pclk) toggles++;
            prev_pclk = camera_pclk;
            if (camera_href || camera_vsync || camera_data != 0 || frame_done || busy) quiet_bad++;
        end
        check("idle_pclk_toggles", toggles, 100);
        check("idle_outputs_quiet", quiet_bad, 0);

        for (int v = 0; v < 4; v++) begin
            reset_dut();
            pattern_sel = vecs[v].pat;
            solid_color = vecs[v].solid;
            repeat (4) step();
            enable = 1'b1;
            run_until_done(1000);
            repeat (100) step();
            analyze();
            check($sformatf("v%0d_vsync_found", v), (vs_idx >= 0), 1);
            check($sformatf("v%0d_vsync_periods", v), n_vs, 20);
            check($sformatf("v%0d_href_pulses", v), n_runs, 4);
            check($sformatf("v%0d_href_len_bad", v), n_badlen, 0);
            check($sformatf("v%0d_data_idle_zero", v), n_dirty, 0);
            check($sformatf("v%0d_done_count", v), done_at.size(), 1);
            check($sformatf("v%0d_done_offset", v), done_idx - vs_idx, 140);
            for (int l = 0; l < 4; l++) begin
                exp_line = vecs[v].line0;
                if (vecs[v].pat == 2'd3)
                    for (int i = 0; i < 16; i++)
                        exp_line[127-8*i -: 8] = exp_line[127-8*i -: 8] + 8'(16 * l);
                check($sformatf("v%0d_line%0d_bytes", v, l), lines[l], exp_line);
            end
            nogap = (done_idx < rec_vsync.size()) ? rec_vsync[done_idx] : 1'b0;
            check($sformatf("v%0d_back_to_back_vsync", v), nogap, 1);
            first2 = 9'h100;
            for (int j = done_idx; j < rec_href.size(); j++)
                if (rec_href[j] && first2 == 9'h100) first2 = {1'b0, rec_data[j]};
            check($sformatf("v%0d_frame2_first_byte", v), first2, {1'b0, vecs[v].line0[127:120]});
            check($sformatf("v%0d_busy_running", v), busy, 1);
        end

        // Enable dropped during active line 1; the frame still completes with latched inputs.
        reset_dut();
        pattern_sel = 2'd0;
        solid_color = 16'hF81F;
        repeat (4) step();
        enable = 1'b1;
        c = 0;
        while (href_seen < 17 && c < 1000) begin
            step();
            c++;
        end
        enable = 1'b0;
        solid_color = 16'h0000;
        pattern_sel = 2'd2;
        run_until_done(1000);
        repeat (100) step();
        analyze();
        late_vs = 0;
        for (int j = done_idx; j < rec_vsync.size(); j++) if (rec_vsync[j]) late_vs++;
        check("drop_en_href_pulses", n_runs, 4);
        check("drop_en_line3_latched", lines[3], 128'hF81FF81FF81FF81FF81FF81FF81FF81F);
        check("drop_en_done_count", done_at.size(), 1);
        check("drop_en_done_offset", done_idx - vs_idx, 140);
        check("drop_en_no_new_frame", late_vs, 0);
        check("drop_en_busy_low", busy, 0);

        // Reset in the middle of an href pulse.
        reset_dut();
        pattern_sel = 2'd0;
        solid_color = 16'hFFFF;
        repeat (4) step();
        enable = 1'b1;
        c = 0;
        while (href_seen < 5 && c < 1000) begin
            step();
            c++;
        end
        check("pre_reset_href_high", camera_href, 1);
        #2 reset = 1'b1;
        #1 check("reset_async_clear",
                 {camera_pclk, camera_href, camera_vsync, camera_data, frame_done, busy}, 0);
        clear_rec();
        repeat (10) step();
        check("reset_no_done", done_at.size(), 0);
        reset = 1'b0;
        clear_rec();
        run_until_done(1000);
        analyze();
        pre_href = 0;
        first_href = (vs_idx < 0) ? rec_href.size() : vs_idx;
        for (int j = 0; j < first_href; j++) if (rec_href[j]) pre_href++;
        check("restart_vsync_found", (vs_idx >= 0), 1);
        check("restart_no_href_before_vsync", pre_href, 0);
        check("restart_vsync_periods", n_vs, 20);
        check("restart_done_offset", done_idx - vs_idx, 140);
        check("restart_line0_bytes", lines[0], 128'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/camera_stream_gen.md
Name: camera_stream_gen

Overview:
Synthesizable OV7670-style camera sensor emulator. It drives camera_pclk, camera_href, camera_vsync and camera_data with test-pattern RGB565 frames. It is the transmitter counterpart of the camera_full capture path. Its outputs connect directly to camera_full's camera_* inputs for bench and on-board bring-up without a physical sensor.

Parameters:
H_ACTIVE, 640, active pixels per line (multiple of 8)
V_ACTIVE, 480, active lines per frame
H_BLANK, 144, pclk periods per line with href low
VSYNC_LINES, 3, lines with vsync high at frame start
V_BACK, 17, blank lines after vsync
V_FRONT, 10, blank lines after the active region
PCLK_HALF, 2, clk_50 cycles per pclk half-period (>=1)

Ports:
clk_50  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  level; frames are generated while high
pattern_sel  in  2  0 solid, 1 ramp, 2 colour bars, 3 byte counter
solid_color  in  16  RGB565 value for pattern 0
camera_pclk  out  1  emulated pixel clock, free-running
camera_href  out  1  line-valid
camera_vsync  out  1  frame sync, active high
camera_data  out  8  pixel byte
frame_done  out  1  one-cycle pulse at frame end
busy  out  1  high when state != IDLE

Behaviour:
- Reset: all outputs 0, state IDLE, all counters 0. Assertion mid-frame aborts the frame immediately with no frame_done.
- pclk: a half-period counter toggles camera_pclk every PCLK_HALF clk_50 cycles, free-running from reset release. A "tick" is the clk_50 cycle in which pclk goes 1->0.
- All of href, vsync, data, the counters and the FSM update only on ticks. The receiver therefore samples stable data on the rising pclk edge.
- Line = 2*H_ACTIVE + H_BLANK ticks, tracked by column counter col. href=1 for col < 2*H_ACTIVE, except in IDLE.
- FSM states: IDLE -> VSYNC -> VBACK -> ACTIVE -> VFRONT.
  - IDLE: outputs low. At a tick with enable=1, go to VSYNC with col=0 and line=0. pattern_sel and solid_color are latched here and held for the whole frame.
  - VSYNC: vsync=1 for VSYNC_LINES lines, href=0.
  - VBACK: V_BACK lines, href=0.
  - ACTIVE: V_ACTIVE lines, href pulses as defined above.
  - VFRONT: V_FRONT lines, href=0. At the last tick of the last line, pulse frame_done for one clk_50 cycle. Then go to VSYNC if enable=1 (relatching the inputs), else IDLE.
- Dropping enable mid-frame does not stop the current frame. The frame completes and the FSM then returns to IDLE.
- Pixel x = col>>1; high byte is sent first (col even), then the low byte. camera_data = 0x00 whenever href=0.
- Pattern 0: solid_color.
- Pattern 1: pixel = {x[8:4], x[8:3], x[8:4]}.
- Pattern 2: 8 vertical bars, each H_ACTIVE/8 pixels wide, in order FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
  - The bar index is a counter that increments every H_ACTIVE/8 pixels and resets at each line start. No divider.
- Pattern 3: camera_data is an 8-bit counter that increments per active byte, wraps 0xFF->0x00, and clears at VSYNC entry.

Decomposition:
- Package camera_stream_pkg holds:
  - the state enum
  - the 8 bar-colour RGB565 constants
  - the pattern_sel encodings
  - PIXEL_W = 16
- One sub-module, camera_pattern_pixel, maps (pattern, x, bar index, solid colour, byte counter, byte select) to data_byte. It is combinational and registered by the parent on the tick.

Test Plan:
All scenarios use bench parameters H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VSYNC_LINES=1, V_BACK=1, V_FRONT=1, PCLK_HALF=1.
1. Reset release with enable=0 -> pclk period is 2 clk_50 cycles, all other outputs stay 0 for 100 cycles, busy=0.
2. enable=1, pattern 0, solid_color=0xF81F -> vsync high for exactly 20 pclk periods. Each of 4 href pulses is 16 pclk periods long, with bytes alternating F8,1F. frame_done pulses once, 140 pclk periods after VSYNC entry.
3. Pattern 2 -> each line reads FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00.
4. Pattern 3 with enable held -> line 0 bytes are 00..0F and line 3 ends at 3F. The second frame restarts at 00 with no idle gap between frames.
5. enable dropped during ACTIVE line 1 -> the frame completes, frame_done pulses, the FSM enters IDLE, and busy falls to 0.
6. reset asserted mid-href -> all outputs are 0 asynchronously and no frame_done pulse occurs. After release with enable=1, a fresh frame starts with VSYNC.
